// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, exception codes,
// FSM states and the legacy reset/stall/branch constants.
package pipe_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic NOSTOP     = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic BRANCH     = 1'b1;
    localparam logic NOT_BRANCH = 1'b0;

    // Bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXCEPT_NONE = 32'h00000000;
    localparam logic [31:0] EXCEPT_ERET = 32'h0000000e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrl_state_e;

    function automatic logic [5:0] stall_encode(input logic id, input logic ex, input logic mem);
        if (mem) return STALL_MEM;
        if (ex)  return STALL_EX;
        if (id)  return STALL_ID;
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Total stall-cycle counter plus a sticky flag raised after WDOG_LIMIT
// consecutive PC-stall cycles.
module pipe_ctrl_stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1023
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        stall,
    output logic [31:0] stall_cycles,
    output logic        stall_timeout
);

    localparam int unsigned CNT_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WDOG_LIMIT - 1);

    logic [CNT_W-1:0] wdog_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Rst == RST_ENABLE) begin
            stall_cycles  <= '0;
            wdog_cnt      <= '0;
            stall_timeout <= 1'b0;
        end else if (stall == STOP) begin
            stall_cycles <= stall_cycles + 32'd1;
            // Saturate so a very long stall cannot wrap back below the limit.
            if (wdog_cnt != LIMIT) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_cnt == LIMIT_M1) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall vector, PC redirect arbitration, exception flush
// sequencing and buffering of branches resolved while the PC is frozen.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WDOG_LIMIT   = 1023
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        branch_flag_o,
    output logic [31:0] branch_target_o,
    output logic [31:0] stall_cycles_o,
    output logic        stall_timeout_o
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    ctrl_state_e state, state_next;
    logic [2:0]  flush_cnt, flush_cnt_next;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        exc_detect;
    logic [31:0] exc_pc;

    // Exceptions are only honoured in RUN; during FLUSH they come from squashed slots.
    assign exc_detect = (state == ST_RUN) && (excepttype_i != EXCEPT_NONE);
    assign exc_pc     = (excepttype_i == EXCEPT_ERET) ? cp0_epc_i : EXC_VECTOR;
    assign flush_o    = (state == ST_FLUSH);

    // NOTE: combinational blocks assign every output a default first so no
    // path through the case/if tree leaves a latch behind.
    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        case (state)
            ST_RUN: begin
                if (exc_detect) begin
                    state_next     = ST_FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt <= 3'd1) begin
                    state_next = ST_RUN;
                end else begin
                    flush_cnt_next = flush_cnt - 3'd1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_comb begin
        stall_o         = STALL_NONE;
        branch_flag_o   = NOT_BRANCH;
        branch_target_o = '0;
        if (Rst != RST_ENABLE) begin
            // The exception wins the PC in the detect cycle, so no branch leaves then.
            if ((state == ST_RUN) && !exc_detect) begin
                stall_o = stall_encode(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
                if ((stall_o[0] == NOSTOP) && (pend_valid || branch_flag_i)) begin
                    branch_flag_o = BRANCH;
                end
            end
            branch_target_o = pend_valid ? pend_target : branch_target_i;
        end
    end

    // NOTE: reset is synchronous and active-high to match the rest of the core.
    always_ff @(posedge Clk) begin
        if (Rst == RST_ENABLE) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst == RST_ENABLE) begin
            new_pc_o    <= '0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (exc_detect) begin
            new_pc_o   <= exc_pc;
            pend_valid <= 1'b0;
        end else if (state == ST_RUN) begin
            if (stall_o[0] == NOSTOP) begin
                pend_valid <= 1'b0;
            end else if (branch_flag_i && !pend_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= branch_target_i;
            end
        end
    end

    pipe_ctrl_stall_watchdog #(
        .WDOG_LIMIT(WDOG_LIMIT)
    ) u_watchdog (
        .Clk          (Clk),
        .Rst          (Rst),
        .stall        (stall_o[0]),
        .stall_cycles (stall_cycles_o),
        .stall_timeout(stall_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, branch buffering, exception
// and ERET flush, flush vs pending branch, watchdog and synchronous reset.
module tb_pipe_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        branch_flag_o;
    logic [31:0] branch_target_o;
    logic [31:0] stall_cycles_o;
    logic        stall_timeout_o;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    pipe_ctrl #(
        .EXC_VECTOR  (32'h00000020),
        .FLUSH_CYCLES(1),
        .WDOG_LIMIT  (8)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .stallreq_id_i  (stallreq_id_i),
        .stallreq_ex_i  (stallreq_ex_i),
        .stallreq_mem_i (stallreq_mem_i),
        .excepttype_i   (excepttype_i),
        .cp0_epc_i      (cp0_epc_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .new_pc_o       (new_pc_o),
        .branch_flag_o  (branch_flag_o),
        .branch_target_o(branch_target_o),
        .stall_cycles_o (stall_cycles_o),
        .stall_timeout_o(stall_timeout_o)
    );

    task automatic idle_inputs();
        stallreq_id_i   = 1'b0;
        stallreq_ex_i   = 1'b0;
        stallreq_mem_i  = 1'b0;
        excepttype_i    = 32'h0;
        cp0_epc_i       = 32'h0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rst = 1'b1;
        stallreq_mem_i  = 1'b1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h55;
        @(negedge Clk);
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL rst_stall got %b exp 000000", stall_o); end
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL rst_bflag got %b exp 0", branch_flag_o); end
        checks++; if (branch_target_o !== 32'h0) begin errors++; $display("FAIL rst_btarget got %h exp 0", branch_target_o); end
        next_cycle();
        Rst = 1'b0;
        idle_inputs();
        @(negedge Clk);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", flush_o); end
        checks++; if (new_pc_o !== 32'h0) begin errors++; $display("FAIL rst_newpc got %h exp 0", new_pc_o); end
        checks++; if (stall_cycles_o !== 32'd0) begin errors++; $display("FAIL rst_cycles got %0d exp 0", stall_cycles_o); end
        checks++; if (stall_timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", stall_timeout_o); end
        next_cycle();
    endtask

    task automatic test_stall_priority();
        logic [5:0] exp_vec [4];
        exp_vec[0] = 6'b000111;
        exp_vec[1] = 6'b001111;
        exp_vec[2] = 6'b011111;
        exp_vec[3] = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            stallreq_id_i  = (i < 3);
            stallreq_ex_i  = (i == 1) || (i == 2);
            stallreq_mem_i = (i == 2);
            @(negedge Clk);
            checks++; if (stall_o !== exp_vec[i]) begin errors++; $display("FAIL prio_%0d got %b exp %b", i, stall_o, exp_vec[i]); end
            next_cycle();
        end
        checks++; if (stall_cycles_o !== 32'd3) begin errors++; $display("FAIL prio_cycles got %0d exp 3", stall_cycles_o); end
        idle_inputs();
    endtask

    task automatic test_branch_buffer();
        stallreq_ex_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h100;
        @(negedge Clk);
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL buf_c1_flag got %b exp 0", branch_flag_o); end
        next_cycle();
        branch_target_i = 32'h200;
        @(negedge Clk);
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL buf_c2_flag got %b exp 0", branch_flag_o); end
        checks++; if (branch_target_o !== 32'h100) begin errors++; $display("FAIL buf_c2_target got %h exp 100", branch_target_o); end
        next_cycle();
        branch_flag_i = 1'b0;
        @(negedge Clk);
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL buf_c3_flag got %b exp 0", branch_flag_o); end
        next_cycle();
        stallreq_ex_i = 1'b0; branch_target_i = 32'h999;
        @(negedge Clk);
        checks++; if (branch_flag_o !== 1'b1) begin errors++; $display("FAIL buf_rel_flag got %b exp 1", branch_flag_o); end
        checks++; if (branch_target_o !== 32'h100) begin errors++; $display("FAIL buf_rel_target got %h exp 100", branch_target_o); end
        next_cycle();
        @(negedge Clk);
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL buf_clr_flag got %b exp 0", branch_flag_o); end
        checks++; if (branch_target_o !== 32'h999) begin errors++; $display("FAIL buf_clr_target got %h exp 999", branch_target_o); end
        checks++; if (stall_cycles_o !== 32'd6) begin errors++; $display("FAIL buf_cycles got %0d exp 6", stall_cycles_o); end
        next_cycle();
        branch_flag_i = 1'b1; branch_target_i = 32'h40;
        @(negedge Clk);
        checks++; if ({branch_flag_o, branch_target_o} !== {1'b1, 32'h40}) begin errors++; $display("FAIL buf_direct got %b/%h exp 1/40", branch_flag_o, branch_target_o); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_exception();
        excepttype_i = 32'h8; stallreq_id_i = 1'b1;
        @(negedge Clk);
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL exc_detect_stall got %b exp 000000", stall_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL exc_detect_flush got %b exp 0", flush_o); end
        next_cycle();
        excepttype_i = 32'hc; branch_flag_i = 1'b1; branch_target_i = 32'h80;
        @(negedge Clk);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL exc_flush got %b exp 1", flush_o); end
        checks++; if (new_pc_o !== 32'h20) begin errors++; $display("FAIL exc_newpc got %h exp 20", new_pc_o); end
        checks++; if (stall_o !== 6'b000000) begin errors++; $display("FAIL exc_flush_stall got %b exp 000000", stall_o); end
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL exc_flush_bflag got %b exp 0", branch_flag_o); end
        next_cycle();
        idle_inputs();
        @(negedge Clk);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL exc_ignored_flush got %b exp 0", flush_o); end
        checks++; if (new_pc_o !== 32'h20) begin errors++; $display("FAIL exc_hold_newpc got %h exp 20", new_pc_o); end
        checks++; if (stall_cycles_o !== 32'd6) begin errors++; $display("FAIL exc_cycles got %0d exp 6", stall_cycles_o); end
        next_cycle();
    endtask

    task automatic test_eret();
        cp0_epc_i = 32'h4000; excepttype_i = 32'he;
        next_cycle();
        idle_inputs();
        @(negedge Clk);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL eret_flush got %b exp 1", flush_o); end
        checks++; if (new_pc_o !== 32'h4000) begin errors++; $display("FAIL eret_newpc got %h exp 4000", new_pc_o); end
        next_cycle();
        @(negedge Clk);
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL eret_end got %b exp 0", flush_o); end
        next_cycle();
    endtask

    task automatic test_flush_kills_pending();
        stallreq_mem_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h300;
        @(negedge Clk);
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL kill_stall_flag got %b exp 0", branch_flag_o); end
        next_cycle();
        branch_flag_i = 1'b0; branch_target_i = 32'h0; excepttype_i = 32'h8;
        next_cycle();
        idle_inputs();
        @(negedge Clk);
        checks++; if ({flush_o, new_pc_o} !== {1'b1, 32'h20}) begin errors++; $display("FAIL kill_flush got %b/%h exp 1/20", flush_o, new_pc_o); end
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL kill_flush_bflag got %b exp 0", branch_flag_o); end
        next_cycle();
        @(negedge Clk);
        checks++; if (branch_flag_o !== 1'b0) begin errors++; $display("FAIL kill_after_bflag got %b exp 0", branch_flag_o); end
        checks++; if (branch_target_o !== 32'h0) begin errors++; $display("FAIL kill_after_target got %h exp 0", branch_target_o); end
        checks++; if (stall_cycles_o !== 32'd7) begin errors++; $display("FAIL kill_cycles got %0d exp 7", stall_cycles_o); end
        next_cycle();
    endtask

    task automatic test_watchdog();
        stallreq_mem_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            checks++; if (stall_timeout_o !== (i > 8)) begin errors++; $display("FAIL wdog_c%0d got %b exp %b", i, stall_timeout_o, (i > 8)); end
            next_cycle();
        end
        stallreq_mem_i = 1'b0;
        @(negedge Clk);
        checks++; if (stall_timeout_o !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b exp 1", stall_timeout_o); end
        checks++; if (stall_cycles_o !== 32'd17) begin errors++; $display("FAIL wdog_cycles got %0d exp 17", stall_cycles_o); end
        next_cycle();
        @(negedge Clk);
        checks++; if (stall_timeout_o !== 1'b1) begin errors++; $display("FAIL wdog_sticky2 got %b exp 1", stall_timeout_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid_flush();
        excepttype_i = 32'h8;
        next_cycle();
        excepttype_i = 32'h0; Rst = 1'b1;
        @(negedge Clk);
        checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL rflush_pre got %b exp 1", flush_o); end
        next_cycle();
        Rst = 1'b0; stallreq_id_i = 1'b1;
        @(negedge Clk);
        checks++; if ({flush_o, new_pc_o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rflush_out got %b/%h exp 0/0", flush_o, new_pc_o); end
        checks++; if ({stall_cycles_o, stall_timeout_o} !== {32'd0, 1'b0}) begin errors++; $display("FAIL rflush_wdog got %0d/%b exp 0/0", stall_cycles_o, stall_timeout_o); end
        checks++; if (stall_o !== 6'b000111) begin errors++; $display("FAIL rflush_run got %b exp 000111", stall_o); end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid_pending();
        stallreq_ex_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h700;
        next_cycle();
        idle_inputs();
        Rst = 1'b1;
        @(negedge Clk);
        checks++; if ({branch_flag_o, branch_target_o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rpend_in got %b/%h exp 0/0", branch_flag_o, branch_target_o); end
        next_cycle();
        Rst = 1'b0;
        @(negedge Clk);
        checks++; if ({branch_flag_o, branch_target_o} !== {1'b0, 32'h0}) begin errors++; $display("FAIL rpend_after got %b/%h exp 0/0", branch_flag_o, branch_target_o); end
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout got running exp finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_stall_priority();
        test_branch_buffer();
        test_exception();
        test_eret();
        test_flush_kills_pending();
        test_watchdog();
        test_reset_mid_flush();
        test_reset_mid_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Turns per-stage stall requests into the 6-bit stall vector consumed by the PC register and the stage latches. Stall bit 0 is the PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
- Arbitrates PC redirects: exception/ERET over branch.
- Sequences the exception flush and buffers a branch that arrives while the PC is frozen.
- Keeps a stall-cycle counter and a stall watchdog.

Parameters:
EXC_VECTOR, 32'h00000020, exception entry address.
FLUSH_CYCLES, 1, number of cycles flush_o is held (1..7).
WDOG_LIMIT, 1023, consecutive stall[0] cycles before stall_timeout_o asserts.

Ports:
Clk  in  1  clock
Rst  in  1  synchronous reset, active-high
stallreq_id_i  in  1  ID stall request (load-use)
stallreq_ex_i  in  1  EX stall request (multi-cycle div/madd)
stallreq_mem_i  in  1  MEM stall request (data bus wait)
excepttype_i  in  32  MEM-stage exception type; 0 = none
cp0_epc_i  in  32  current CP0 EPC
branch_flag_i  in  1  ID-stage branch taken
branch_target_i  in  32  ID-stage branch target
stall_o  out  6  stall vector
flush_o  out  1  flush all stage latches; PC loads new_pc_o
new_pc_o  out  32  redirect address while flush_o=1
branch_flag_o  out  1  arbitrated branch to PC register
branch_target_o  out  32  arbitrated branch target
stall_cycles_o  out  32  count of cycles with stall_o[0]=1
stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
Reset:
- Rst=1 at a clock edge forces state=RUN, flush_o=0, new_pc_o=0, pend_valid=0, stall_cycles_o=0, watchdog count=0, stall_timeout_o=0.
- stall_o=0, branch_flag_o=0 and branch_target_o=0 whenever Rst=1.
- Rst overrides everything, including mid-flush and mid-pending.

FSM states: RUN, FLUSH.
- RUN, excepttype_i!=0:
  - Next state FLUSH; flush_o=1 from the next cycle for FLUSH_CYCLES cycles.
  - new_pc_o is registered in the same cycle: cp0_epc_i if excepttype_i==32'h0000000e (ERET), else EXC_VECTOR.
- FLUSH:
  - stall_o=0, branch_flag_o=0.
  - excepttype_i is ignored, since it comes from squashed instructions.
  - A down-counter returns the FSM to RUN after FLUSH_CYCLES cycles.
  - new_pc_o holds its value until the next exception.

stall_o (combinational, RUN only; highest request wins):
- mem: 6'b011111
- ex: 6'b001111
- id: 6'b000111
- none: 6'b000000
- In the detect cycle (RUN with excepttype_i!=0), stall_o=0.

Pending branch:
- In RUN, branch_flag_i=1 while stall_o[0]=1 latches pend_valid=1 and pend_target=branch_target_i. The first latch wins; later branches do not overwrite it.
- branch_flag_o = stall_o[0]==0 and (pend_valid or branch_flag_i).
- branch_target_o = pend_target if pend_valid, else branch_target_i.
- pend_valid clears on the first cycle stall_o[0]==0 in RUN.
- Entering FLUSH clears pend_valid; the exception wins over a buffered branch.

Counters:
- stall_cycles_o increments each cycle stall_o[0]=1 and wraps at 2^32.
- Watchdog count increments on consecutive stall_o[0]=1 cycles and clears on any stall_o[0]=0 cycle.
- When the count reaches WDOG_LIMIT, stall_timeout_o is set on that edge and stays set until Rst.

Decomposition:
- Shared define file:
  - stall encodings STALL_NONE/ID/EX/MEM
  - EXCEPT_ERET=32'h0000000e
  - state encodings
  - existing RstEnable/NOSTOP/Branch macros
- Optional sub-module stall_watchdog, holding the stall counter and the sticky timeout. Everything else stays in pipe_ctrl.

Test Plan:
- Stall priority: stallreq_id=1, then id+ex, then id+ex+mem -> stall_o 000111, 001111, 011111; release -> 000000; stall_cycles_o=3.
- Branch buffering: stallreq_ex=1 for 3 cycles with branch_flag_i=1, target 0x100 in cycle 1 and 0x200 in cycle 2 -> branch_flag_o=0 while stalled; on release one cycle with branch_flag_o=1, target 0x100; then pend clear.
- Exception: excepttype_i=0x8 for one cycle -> next cycle flush_o=1, new_pc_o=0x20, stall_o=0 for 1 cycle; excepttype_i=0xc during FLUSH is ignored.
- ERET: cp0_epc_i=0x4000, excepttype_i=0xe -> flush_o=1, new_pc_o=0x4000.
- Flush kills pending branch: pending branch 0x300 under stall, then exception -> no branch_flag_o after the flush; PC redirect only to 0x20.
- Watchdog and reset: WDOG_LIMIT=8, hold stallreq_mem 10 cycles -> stall_timeout_o rises at cycle 8 and stays after release. Rst=1 mid-FLUSH -> all outputs 0 on the next edge, FSM in RUN.
